// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor conditioner: default sizes, counter-width helpers
// and the edge-event encoding consumed by the phase controller.
package sensor_pkg;

  localparam int unsigned DEF_NUM_SENSORS  = 8;
  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEF_RISE_CYCLES  = 4;
  localparam int unsigned DEF_FALL_CYCLES  = 4;
  localparam int unsigned DEF_STUCK_CYCLES = 1024;

  function automatic int unsigned filter_width(int unsigned rise, int unsigned fall);
    return $clog2(((rise > fall) ? rise : fall) + 1);
  endfunction

  function automatic int unsigned stuck_width(int unsigned stuck);
    return $clog2(stuck + 1);
  endfunction

  localparam int unsigned DEF_FC_W    = filter_width(DEF_RISE_CYCLES, DEF_FALL_CYCLES);
  localparam int unsigned DEF_STUCK_W = stuck_width(DEF_STUCK_CYCLES);

  typedef enum logic [1:0] {
    EvtNone,
    EvtRise,
    EvtFall
  } sensor_evt_t;

endpackage

// File: rtl/sensor_channel.sv
// One sensor channel: synchroniser, asymmetric debounce filter, edge strobes,
// saturating vehicle counter and sticky stuck-high detector.
module sensor_channel
  import sensor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned RISE_CYCLES  = DEF_RISE_CYCLES,
  parameter int unsigned FALL_CYCLES  = DEF_FALL_CYCLES,
  parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw,
  input  logic             clear_counts,
  output logic             debounced,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             stuck_fault,
  output logic [CNT_W-1:0] vehicle_count
);

  localparam int unsigned FC_W = filter_width(RISE_CYCLES, FALL_CYCLES);
  localparam int unsigned ST_W = stuck_width(STUCK_CYCLES);
  localparam logic [FC_W-1:0] RISE_LAST = FC_W'(RISE_CYCLES - 1);
  localparam logic [FC_W-1:0] FALL_LAST = FC_W'(FALL_CYCLES - 1);
  localparam logic [ST_W-1:0] STUCK_MAX = ST_W'(STUCK_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [FC_W-1:0]        fc_q, fc_d;
  logic                   deb_q, deb_d;
  sensor_evt_t            evt;
  logic                   rise_q, fall_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ST_W-1:0]        st_q, st_d;
  logic                   fault_q, fault_d;
  logic                   st_set;

  assign s = sync_q[SYNC_STAGES-1];

  // Filter: any agreement between s and the output discards the partial run.
  always_comb begin
    fc_d  = '0;
    deb_d = deb_q;
    evt   = EvtNone;
    if (s != deb_q) begin
      if (fc_q == (s ? RISE_LAST : FALL_LAST)) begin
        deb_d = s;
        evt   = s ? EvtRise : EvtFall;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_counts) begin
      cnt_d = rise_q ? CNT_W'(1) : '0;
    end else if (rise_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A coincident set beats clear_counts and keeps the timer running.
  always_comb begin
    st_d = '0;
    if (deb_q) begin
      st_d = (st_q == STUCK_MAX) ? st_q : st_q + 1'b1;
    end
    st_set  = deb_q && (st_d == STUCK_MAX);
    fault_d = fault_q;
    if (st_set) begin
      fault_d = 1'b1;
    end else if (clear_counts) begin
      fault_d = 1'b0;
      st_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      fc_q    <= '0;
      deb_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      st_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      fc_q    <= fc_d;
      deb_q   <= deb_d;
      rise_q  <= (evt == EvtRise);
      fall_q  <= (evt == EvtFall);
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      fault_q <= fault_d;
    end
  end

  assign debounced     = deb_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign stuck_fault   = fault_q;
  assign vehicle_count = cnt_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Top level: one sensor_channel per input, with the vector buses sliced per channel.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int unsigned NUM_SENSORS  = DEF_NUM_SENSORS,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned RISE_CYCLES  = DEF_RISE_CYCLES,
  parameter int unsigned FALL_CYCLES  = DEF_FALL_CYCLES,
  parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SENSORS-1:0]       raw_sensor,
  input  logic                         clear_counts,
  output logic [NUM_SENSORS-1:0]       debounced_sensor,
  output logic [NUM_SENSORS-1:0]       rise_pulse,
  output logic [NUM_SENSORS-1:0]       fall_pulse,
  output logic [NUM_SENSORS-1:0]       stuck_fault,
  output logic [NUM_SENSORS*CNT_W-1:0] vehicle_count
);

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    sensor_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .RISE_CYCLES (RISE_CYCLES),
      .FALL_CYCLES (FALL_CYCLES),
      .STUCK_CYCLES(STUCK_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .raw          (raw_sensor[i]),
      .clear_counts (clear_counts),
      .debounced    (debounced_sensor[i]),
      .rise_pulse   (rise_pulse[i]),
      .fall_pulse   (fall_pulse[i]),
      .stuck_fault  (stuck_fault[i]),
      .vehicle_count(vehicle_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor matches them.
module tb_sensor_conditioner;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clear_counts = 1'b0;
  logic [N-1:0]    raw = 8'hFF;
  logic [N-1:0]    deb, rise, fall, fault;
  logic [N*CW-1:0] cnt;
  logic [0:0]      a_raw = 1'b0;
  logic [0:0]      a_deb, a_rise, a_fall, a_fault;
  logic [CW-1:0]   a_cnt;
  logic [N:0]      rise_all, fall_all;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit done = 1'b0;

  typedef struct {
    int ch;
    bit is_rise;
    int at;
  } evt_t;
  evt_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sensor_conditioner #(
    .NUM_SENSORS (N),
    .SYNC_STAGES (2),
    .RISE_CYCLES (4),
    .FALL_CYCLES (4),
    .STUCK_CYCLES(16),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .raw_sensor      (raw),
    .clear_counts    (clear_counts),
    .debounced_sensor(deb),
    .rise_pulse      (rise),
    .fall_pulse      (fall),
    .stuck_fault     (fault),
    .vehicle_count   (cnt)
  );

  // Asymmetric filter instance; its strobes appear as channel 8 in the scoreboard.
  sensor_conditioner #(
    .NUM_SENSORS (1),
    .SYNC_STAGES (2),
    .RISE_CYCLES (2),
    .FALL_CYCLES (6),
    .STUCK_CYCLES(16),
    .CNT_W       (CW)
  ) dut_a (
    .clk             (clk),
    .rst             (rst),
    .raw_sensor      (a_raw),
    .clear_counts    (clear_counts),
    .debounced_sensor(a_deb),
    .rise_pulse      (a_rise),
    .fall_pulse      (a_fall),
    .stuck_fault     (a_fault),
    .vehicle_count   (a_cnt)
  );

  assign rise_all = {a_rise, rise};
  assign fall_all = {a_fall, fall};

  task automatic push(input int ch, input bit r, input int at);
    evt_t e;
    e.ch = ch;
    e.is_rise = r;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic match(input int ch, input bit r);
    int idx = -1;
    n_cmp++;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (idx < 0 && exp_q[k].ch == ch && exp_q[k].is_rise == r && exp_q[k].at == cyc) idx = k;
    end
    if (idx >= 0) begin
      exp_q.delete(idx);
    end else begin
      n_bad++;
      $display("FAIL strobe_ch%0d_%s: got strobe at cycle %0d, expected none", ch,
               r ? "rise" : "fall", cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      for (int i = 0; i <= N; i++) begin
        if (rise_all[i]) match(i, 1'b1);
        if (fall_all[i]) match(i, 1'b0);
      end
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
        if (exp_q[k].at < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL event_ch%0d_%s: got no strobe, expected one at cycle %0d",
                   exp_q[k].ch, exp_q[k].is_rise ? "rise" : "fall", exp_q[k].at);
          exp_q.delete(k);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    // Reset held with all inputs high.
    wait_to(3);
    check("rst_deb", 64'(deb), 64'h0);
    check("rst_rise", 64'(rise), 64'h0);
    check("rst_fall", 64'(fall), 64'h0);
    check("rst_fault", 64'(fault), 64'h0);
    check("rst_cnt", 64'(cnt), 64'h0);
    check("rst_a_deb", 64'(a_deb), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) push(i, 1'b1, 9);
    wait_to(10);
    check("first_deb", 64'(deb), 64'hFF);
    check("first_cnt", 64'(cnt), 64'({8{3'd1}}));
    raw = 8'h80;
    for (int i = 0; i < N - 1; i++) push(i, 1'b0, 16);

    // Stuck detection on ch 7: rise after edge 9, fault after edge 25.
    wait_to(24);
    check("stuck_early", 64'(fault), 64'h0);
    wait_to(25);
    check("stuck_set", 64'(fault), 64'h80);
    raw[7] = 1'b0;
    push(7, 1'b0, 31);
    wait_to(32);
    check("stuck_sticky", 64'(fault), 64'h80);
    check("stuck_deb", 64'(deb), 64'h0);
    clear_counts = 1'b1;
    wait_to(33);
    clear_counts = 1'b0;
    check("clear_fault", 64'(fault), 64'h0);
    check("clear_cnt", 64'(cnt), 64'h0);

    // Glitch rejection on ch 2.
    wait_to(40);
    raw[2] = 1'b1;
    wait_to(43);
    raw[2] = 1'b0;
    wait_to(52);
    check("glitch3_deb", 64'(deb), 64'h0);
    check("glitch3_cnt", 64'(cnt), 64'h0);
    raw[2] = 1'b1;
    push(2, 1'b1, 58);
    push(2, 1'b0, 62);
    wait_to(56);
    raw[2] = 1'b0;
    wait_to(59);
    check("pulse4_cnt2", 64'(cnt[2*CW +: CW]), 64'h1);
    wait_to(64);
    raw[2] = 1'b1;
    push(2, 1'b1, 70);
    wait_to(72);
    raw[2] = 1'b0;
    wait_to(74);
    raw[2] = 1'b1;
    wait_to(79);
    check("dip_deb2", 64'(deb[2]), 64'h1);
    raw[2] = 1'b0;
    push(2, 1'b0, 85);
    wait_to(87);
    check("dip_fault", 64'(fault), 64'h0);
    check("dip_cnt2", 64'(cnt[2*CW +: CW]), 64'h2);

    // Saturation on ch 5: nine pulses, count holds at 7.
    for (int k = 0; k < 9; k++) begin
      wait_to(90 + 12 * k);
      raw[5] = 1'b1;
      push(5, 1'b1, 96 + 12 * k);
      push(5, 1'b0, 101 + 12 * k);
      wait_to(95 + 12 * k);
      raw[5] = 1'b0;
    end
    wait_to(198);
    check("sat_cnt5", 64'(cnt[5*CW +: CW]), 64'h7);
    raw[5] = 1'b1;
    push(5, 1'b1, 204);
    push(5, 1'b0, 209);
    wait_to(203);
    raw[5] = 1'b0;
    wait_to(204);
    clear_counts = 1'b1;
    wait_to(205);
    clear_counts = 1'b0;
    check("clear_rise_cnt", 64'(cnt), 64'(24'h1 << 15));
    wait_to(210);

    // Asymmetric filter: rise after 2+2 edges, fall after 2+6 edges.
    wait_to(212);
    a_raw = 1'b1;
    push(8, 1'b1, 216);
    wait_to(215);
    check("asym_rise_early", 64'(a_deb), 64'h0);
    wait_to(216);
    check("asym_rise", 64'(a_deb), 64'h1);
    wait_to(222);
    a_raw = 1'b0;
    push(8, 1'b0, 230);
    wait_to(229);
    check("asym_fall_early", 64'(a_deb), 64'h1);
    wait_to(230);
    check("asym_fall", 64'(a_deb), 64'h0);
    wait_to(232);
    check("asym_cnt", 64'(a_cnt), 64'h1);

    // Reset while ch 1 is one cycle short of asserting.
    wait_to(236);
    raw[1] = 1'b1;
    wait_to(241);
    rst = 1'b1;
    wait_to(242);
    rst = 1'b0;
    check("midrst_deb", 64'(deb), 64'h0);
    check("midrst_cnt", 64'(cnt), 64'h0);
    check("midrst_a_cnt", 64'(a_cnt), 64'h0);
    push(1, 1'b1, 248);
    wait_to(247);
    check("midrst_late", 64'(deb[1]), 64'h0);
    wait_to(249);
    check("midrst_cnt1", 64'(cnt), 64'(24'h1 << 3));
    raw[1] = 1'b0;
    push(1, 1'b0, 255);
    wait_to(258);
    check("end_fault", 64'({a_fault, fault}), 64'h0);

    done = 1'b1;
    foreach (exp_q[k]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL event_ch%0d_%s: got no strobe, expected one at cycle %0d", exp_q[k].ch,
               exp_q[k].is_rise ? "rise" : "fall", exp_q[k].at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Parametrised per-channel conditioner for traffic-loop and push-button sensors: synchronises and debounces `NUM_SENSORS` raw inputs, with independent assert and deassert filter lengths. Produces one-cycle edge strobes, per-channel saturating vehicle counters and a stuck-sensor fault flag. Sits between the pad inputs and the adaptive phase controller, which consumes the debounced levels, the edge strobes and the counts.

## Interface
Parameters:
- `NUM_SENSORS`, 8: number of independent channels (≥1)
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2)
- `RISE_CYCLES`, 4: consecutive synced-high cycles required to assert (≥1)
- `FALL_CYCLES`, 4: consecutive synced-low cycles required to deassert (≥1)
- `STUCK_CYCLES`, 1024: continuous-assert cycles before fault (≥2)
- `CNT_W`, 8: vehicle counter width per channel

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock
- `rst` in 1: synchronous active-high reset
- `raw_sensor` in NUM_SENSORS: asynchronous raw sensor inputs
- `clear_counts` in 1: one-cycle pulse; clears all counters and faults
- `debounced_sensor` out NUM_SENSORS: filtered level
- `rise_pulse` out NUM_SENSORS: one-cycle strobe on debounced 0→1
- `fall_pulse` out NUM_SENSORS: one-cycle strobe on debounced 1→0
- `stuck_fault` out NUM_SENSORS: sticky stuck-high flag
- `vehicle_count` out NUM_SENSORS*CNT_W: channel i occupies bits [i*CNT_W +: CNT_W]

## Operation
- Reset: every output is 0, including counts and faults. Sync chains, filter counters and stuck timers are also 0.
- Reset has priority over all other inputs, including `clear_counts`.
- Sync: `raw_sensor[i]` shifts through SYNC_STAGES flops. The last stage is `s[i]`.
- Filter counter `fc[i]`:
  - When `s[i]==debounced_sensor[i]`: `fc` is cleared.
  - Otherwise `fc` increments.
  - When `fc` equals (target−1) with a mismatch still present, `debounced_sensor[i]` toggles and `fc` clears.
  - The target is RISE_CYCLES when `s=1` and FALL_CYCLES when `s=0`.
  - `fc` width is clog2(max(RISE_CYCLES,FALL_CYCLES)+1).
  - Any mismatch run shorter than the target is discarded.
- Edge strobes:
  - `rise_pulse`/`fall_pulse` are registered and high for exactly the cycle in which the new `debounced_sensor` value first appears.
  - The two strobes are never both high for the same channel.
- Vehicle count:
  - Increments on each rise event.
  - Saturates at 2^CNT_W−1; no wrap.
  - `clear_counts` sets the count to 0. If a rise event occurs in the same cycle, the count becomes 1.
- Stuck detection:
  - The timer increments while `debounced_sensor[i]==1`, saturating at STUCK_CYCLES, and clears while it is 0.
  - `stuck_fault[i]` sets when the timer reaches STUCK_CYCLES.
  - The fault stays set through a later deassert and clears only on `clear_counts` or `rst`.
  - If `clear_counts` and the set condition coincide, set wins and the timer is not cleared.
- Channels are fully independent; `clear_counts` is the only shared control.

## Timing
- Count the first `clk` edge that samples a new stable `raw_sensor` level as edge 1.
  - `debounced_sensor` changes after edge SYNC_STAGES+RISE_CYCLES when rising, or SYNC_STAGES+FALL_CYCLES when falling. With defaults this is edge 6 in both directions.
  - The strobe is high in that same cycle.
  - `vehicle_count` updates one edge later (registered from the rise event).
- Stuck fault asserts STUCK_CYCLES edges after `debounced_sensor` rises, with the timer counting from the first cycle the level is high.
- Every output is a direct flop output; there are no combinational paths from input to output.
- A raw pulse of width W cycles produces an assert only if W ≥ RISE_CYCLES. A low glitch of W < FALL_CYCLES on an asserted channel produces no fall.

## Structure
- Shared package `sensor_pkg` holds:
  - default `NUM_SENSORS` and `CNT_W` localparams
  - the `clog2`-derived filter/stuck counter widths
  - an enumerated `sensor_evt_t` (NONE, RISE, FALL) used by the controller
- Sub-module `sensor_channel` holds one channel's full logic (sync, filter, strobes, counter, stuck timer). It is instantiated NUM_SENSORS times in a generate loop. The top level only slices the vector buses.

## Test plan
- Reset: hold `rst` with `raw_sensor`=8'hFF for 3 cycles → all outputs 0. Release → `debounced_sensor[0]` rises after edge 6, `rise_pulse` high for 1 cycle, `vehicle_count[0]`=1.
- Glitch rejection (RISE=4): 3-cycle high pulse on ch 2 → no change on any output. A 4-cycle pulse → rise then fall strobes. A 2-cycle low dip while asserted → no fall.
- Asymmetric filter (RISE=2, FALL=6): a step up asserts after edge 4; a step down deasserts after edge 8.
- Saturation (CNT_W=3): 9 clean pulses on ch 5 → count stops at 7. `clear_counts` coincident with a 10th rise → count=1.
- Stuck (STUCK_CYCLES=16): hold ch 7 high → `stuck_fault[7]` sets 16 cycles after assert. Drop the input → fault stays set. `clear_counts` → fault 0.
- Mid-operation reset: assert `rst` while ch 1 has `fc`=3 of 4 → next cycle all state is 0, and the subsequent rise needs a full 6 edges.
